// File: rtl/rx_mod_counter.sv
// Parametrised modulo counter for receive framing: up/down, wrap or saturate, clear/load, tc pulse.
// Define RX_CNT_WRAP_STATS_EN to build the wrap_cnt port and its WRAP_W-bit event counter.
module rx_mod_counter #(
  parameter int WIDTH  = 4
`ifdef RX_CNT_WRAP_STATS_EN
  , parameter int WRAP_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count_en,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
`ifdef RX_CNT_WRAP_STATS_EN
  , output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  logic [WIDTH-1:0] step_val;
  logic             end_ev;

  // Step result. Every increment is guarded by count < limit and every
  // decrement by count != 0, so the result always fits in WIDTH bits.
  always_comb begin
    step_val = count;
    end_ev   = 1'b0;
    if (dir) begin
      if (count < limit) begin
        step_val = count + WIDTH'(1);
      end else begin
        end_ev   = 1'b1;
        step_val = sat ? limit : '0;
      end
    end else begin
      if (count > limit) begin
        step_val = limit;
      end else if (count != '0) begin
        step_val = count - WIDTH'(1);
      end else begin
        end_ev   = 1'b1;
        step_val = sat ? '0 : limit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_val;
      tc    <= 1'b0;
    end else if (count_en) begin
      count <= step_val;
      tc    <= end_ev;
    end else begin
      tc    <= 1'b0;
    end
  end

`ifdef RX_CNT_WRAP_STATS_EN
  // Counts wrap-mode end events only; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clear)
      wrap_cnt <= '0;
    else if (!load && count_en && end_ev && !sat && (wrap_cnt != '1))
      wrap_cnt <= wrap_cnt + WRAP_W'(1);
  end
`endif

  assign at_max  = (count == limit);
  assign at_zero = (count == '0);

endmodule

// File: tb/tb_rx_mod_counter.sv
// Self-checking bench for rx_mod_counter: directed test-plan steps then random traffic vs a reference model.
module tb_rx_mod_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, clear, load, count_en, dir, sat;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] count;
  logic         tc, at_max, at_zero;
`ifdef RX_CNT_WRAP_STATS_EN
  logic [7:0]   wrap_cnt;
  logic [W-1:0] count2;
  logic         tc2, at_max2, at_zero2;
  logic [1:0]   wrap_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  // reference state
  int m_cnt, m_tc, m_w8, m_w2;

  always #5 clk = ~clk;

`ifdef RX_CNT_WRAP_STATS_EN
  rx_mod_counter #(.WIDTH(W), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .count_en(count_en), .dir(dir), .limit(limit), .sat(sat),
    .count(count), .tc(tc), .at_max(at_max), .at_zero(at_zero), .wrap_cnt(wrap_cnt));
  rx_mod_counter #(.WIDTH(W), .WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .count_en(count_en), .dir(dir), .limit(limit), .sat(sat),
    .count(count2), .tc(tc2), .at_max(at_max2), .at_zero(at_zero2), .wrap_cnt(wrap_cnt2));
`else
  rx_mod_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .count_en(count_en), .dir(dir), .limit(limit), .sat(sat),
    .count(count), .tc(tc), .at_max(at_max), .at_zero(at_zero));
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Spec-level behaviour of one clock edge, in plain integers.
  task automatic model_edge();
    int c, L, ev;
    c = m_cnt; L = int'(limit); ev = 0;
    if (rst || clear) begin
      m_cnt = 0; m_tc = 0; m_w8 = 0; m_w2 = 0;
      return;
    end
    if (load) begin
      m_cnt = int'(load_val); m_tc = 0;
      return;
    end
    if (!count_en) begin
      m_tc = 0;
      return;
    end
    if (dir) begin
      if (c < L) c = c + 1;
      else begin ev = 1; c = sat ? L : 0; end
    end else begin
      if (c > L) c = L;
      else if (c > 0) c = c - 1;
      else begin ev = 1; c = sat ? 0 : L; end
    end
    m_cnt = c;
    m_tc  = ev;
    if (ev && !sat) begin
      if (m_w8 < 255) m_w8++;
      if (m_w2 < 3)   m_w2++;
    end
  endtask

  task automatic check_comb(input string tag);
    #1;
    chk({tag, ".at_max"},  int'(at_max),  int'(m_cnt == int'(limit)));
    chk({tag, ".at_zero"}, int'(at_zero), int'(m_cnt == 0));
  endtask

  // One edge: update the model from the current inputs, then compare registered outputs.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".count"}, int'(count), m_cnt);
    chk({tag, ".tc"},    int'(tc),    m_tc);
    chk({tag, ".at_max"},  int'(at_max),  int'(m_cnt == int'(limit)));
    chk({tag, ".at_zero"}, int'(at_zero), int'(m_cnt == 0));
`ifdef RX_CNT_WRAP_STATS_EN
    chk({tag, ".wrap_cnt"},  int'(wrap_cnt),  m_w8);
    chk({tag, ".count2"},    int'(count2),    m_cnt);
    chk({tag, ".wrap_cnt2"}, int'(wrap_cnt2), m_w2);
`endif
  endtask

  task automatic idle();
    rst = 0; clear = 0; load = 0; count_en = 0;
  endtask

  initial begin
    m_cnt = 0; m_tc = 0; m_w8 = 0; m_w2 = 0;
    idle();
    rst = 1; dir = 1; sat = 0; load_val = '0; limit = 4'd13;
    cycle("reset");
    chk("reset.count_const", int'(count), 0);
    chk("reset.at_zero_const", int'(at_zero), 1);

    // legacy 0..13 equivalence
    idle(); count_en = 1; dir = 1; sat = 0; limit = 4'd13;
    for (int i = 0; i < 30; i++) cycle("legacy");
    chk("legacy.final_count", int'(count), 2);
`ifdef RX_CNT_WRAP_STATS_EN
    chk("legacy.wraps", int'(wrap_cnt), 2);
`endif

    // down / saturate
    idle(); load = 1; load_val = 4'd2; limit = 4'd9;
    cycle("dsat.load");
    idle(); count_en = 1; dir = 0; sat = 1;
    for (int i = 0; i < 5; i++) cycle("dsat");
    chk("dsat.final_zero", int'(count), 0);

    // priority
    idle(); clear = 1; load = 1; load_val = 4'd5; count_en = 1; dir = 1; sat = 0;
    cycle("prio.clear");
    idle(); load = 1; count_en = 1;
    cycle("prio.load");
    chk("prio.load_val", int'(count), 5);

    // limit lowered below count
    idle(); load = 1; load_val = 4'd12; limit = 4'd15;
    cycle("lower.load");
    idle(); count_en = 1; dir = 1; sat = 0; limit = 4'd4;
    check_comb("lower.comb");
    cycle("lower.wrap");
    chk("lower.wrap_tc", int'(tc), 1);
    idle(); load = 1; load_val = 4'd12; limit = 4'd15;
    cycle("lower.load2");
    idle(); count_en = 1; dir = 1; sat = 1; limit = 4'd4;
    cycle("lower.sat");
    chk("lower.sat_count", int'(count), 4);

    // reset mid-operation
    idle(); load = 1; load_val = 4'd6; limit = 4'd13; sat = 0;
    cycle("midrst.load");
    idle(); count_en = 1;
    cycle("midrst.step");
    rst = 1; load = 1; load_val = 4'd9;
    cycle("midrst.rst");
    rst = 0; load = 0;
    for (int i = 0; i < 3; i++) cycle("midrst.resume");

    // limit = 0, wrap mode
    idle(); clear = 1;
    cycle("lim0.clear");
    idle(); count_en = 1; dir = 1; sat = 0; limit = '0;
    for (int i = 0; i < 5; i++) cycle("lim0");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      clear    = ($urandom_range(0, 29) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom);
      count_en = ($urandom_range(0, 9) < 7);
      dir      = 1'($urandom);
      if ($urandom_range(0, 19) == 0) sat = 1'($urandom);
      if ($urandom_range(0, 14) == 0) limit = W'($urandom);
      check_comb("rand.pre");
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
